mux_stream_rr: RTL
==================

MUX_STREAM_RR -- requirements
Module: mux_stream_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 8, data width per channel in bits, legal range 1..64.
REQ-003 SHALL derive local parameter SW = clog2(N_CH), the channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, N_CH bits: bit i means channel i presents data.
REQ-007 SHALL have port in_ready, output, N_CH bits: bit i means channel i's data is accepted this cycle.
REQ-008 SHALL have port in_data, input, N_CH*W bits: channel i occupies bits [i*W +: W].
REQ-009 SHALL have port mode, input, 1 bit: 0 selects fixed-select mode, 1 selects round-robin mode.
REQ-010 SHALL have port sel, input, SW bits: the channel index used in fixed-select mode.
REQ-011 SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts the word.
REQ-013 SHALL have port out_data, output, W bits: the registered data word.
REQ-014 SHALL have port out_ch, output, SW bits: the index of the channel that sourced out_data.

Function
REQ-015 SHALL contain one output register stage (out_valid, out_data, out_ch) and a round-robin pointer ptr of SW bits.
REQ-016 SHALL define can_load = !out_valid || out_ready.
REQ-017 SHALL, in fixed mode, grant channel sel when can_load and in_valid[sel]; no grant when sel >= N_CH.
REQ-018 SHALL, in round-robin mode, grant the first channel with in_valid set, searching ptr, ptr+1, ... mod N_CH, when can_load.
REQ-019 SHALL drive in_ready as a one-hot of the granted channel (combinational, same cycle), otherwise all zero; at most one bit set.
REQ-020 SHALL load the output register on the edge after a grant: out_data = granted in_data slice, out_ch = granted index, out_valid = 1.
REQ-021 SHALL clear out_valid on an edge where out_valid && out_ready and there is no grant; out_data and out_ch hold their values.
REQ-022 SHALL, when drain and grant happen in the same cycle, replace the word with no bubble (sustained 1 word/cycle).
REQ-023 SHALL keep out_data and out_ch stable while out_valid && !out_ready.
REQ-024 SHALL set ptr = (granted index + 1) mod N_CH after a round-robin grant, wrapping from N_CH-1 to 0 including non-power-of-2 N_CH.
REQ-025 SHALL hold ptr unchanged on fixed-mode grants and on idle cycles.
REQ-026 SHALL let mode and sel changes take effect on the next grant decision; a word already in the output register is unaffected.
REQ-027 SHALL give a latency of exactly one clock from the in_valid/in_ready handshake to out_valid.

Reset
REQ-028 SHALL, while rst_n is 0, immediately force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, independent of clk.
REQ-029 SHALL drive in_ready to all zero while rst_n is 0.
REQ-030 SHALL, after rst_n rises, make its first grant no earlier than the first rising clk edge.
REQ-031 SHALL discard, with no partial output, any word held when reset asserts mid-transfer.

Verification
REQ-032 SHALL cover fixed mode: N_CH=4, W=8, sel=2, in_valid=4'b1111, data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_ch=2.
REQ-033 SHALL cover round-robin fairness: all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-034 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data/out_ch frozen; out_ready=1 -> drain and same-cycle reload.
REQ-035 SHALL cover sparse round-robin with N_CH=3: only ch2 and ch0 valid, ptr=1 -> grant ch2, ptr wraps to 0, next grant ch0, ptr=1.
REQ-036 SHALL cover an invalid select: N_CH=3, mode=0, sel=3 -> in_ready=0 and out_valid stays 0.
REQ-037 SHALL cover asynchronous reset: rst_n pulled low between clock edges while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 before the next edge; ptr=0 after release.

Source files
------------

// File: rtl/mux_stream_rr.sv
// Registered N-to-1 stream multiplexer with fixed-select and round-robin arbitration.
// One output register stage; a word can be drained and replaced in the same cycle.
module mux_stream_rr #(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic [N_CH*W-1:0] in_data,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch
);

    logic          can_load;
    logic          gnt_any;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    int            idx;

    always_comb begin
        can_load = !out_valid || out_ready;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        idx      = 0;
        if (can_load) begin
            if (!mode) begin
                // An out-of-range sel matches no channel, so nothing is granted.
                for (int i = 0; i < N_CH; i++) begin
                    if (sel == SW'(i) && in_valid[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(i);
                    end
                end
            end else begin
                // Scan from the farthest offset down so the channel nearest ptr wins.
                for (int k = N_CH - 1; k >= 0; k--) begin
                    idx = int'(ptr) + k;
                    if (idx >= N_CH) begin
                        idx = idx - N_CH;
                    end
                    if (in_valid[idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(idx);
                    end
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        if (int'(gnt_idx) == N_CH - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
            if (mode) begin
                ptr <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
